// File: rtl/anton_neopixel_multi_stream_pkg.sv
// Shared encodings and timing constants for the multi-channel WS2812 streamer.
package anton_neopixel_multi_stream_pkg;

  typedef enum logic [1:0] {
    NP_IDLE    = 2'd0,
    NP_PRELOAD = 2'd1,
    NP_STREAM  = 2'd2,
    NP_SYNC    = 2'd3
  } npState_t;

  localparam int T0_HIGH             = 2;
  localparam int T1_HIGH             = 5;
  localparam int RESET_DELAY_DEFAULT = 400;

  // Line level for one data bit at a given tick (8 ticks per bit).
  function automatic logic bitPattern(input logic dataBit, input logic [2:0] tick);
    return tick < (dataBit ? 3'(T1_HIGH) : 3'(T0_HIGH));
  endfunction

endpackage

// File: rtl/anton_neopixel_multi_stream_bit_encoder.sv
// One output lane: shadow byte (prefetch target), shift byte (on the wire) and pulse shaping.
module anton_neopixel_bit_encoder
  import anton_neopixel_multi_stream_pkg::*;
(
  input  logic       clk6_4mhz,
  input  logic       resetn,
  input  logic       clr,
  input  logic       shLoad,
  input  logic [7:0] shData,
  input  logic       xfer,
  input  logic       shiftEn,
  input  logic       en,
  input  logic       active,
  input  logic [2:0] tick,
  output logic       neo
);

  logic [7:0] shadowQ;
  logic [7:0] shiftQ;

  always_ff @(posedge clk6_4mhz or negedge resetn) begin
    if (!resetn) begin
      shadowQ <= '0;
      shiftQ  <= '0;
    end else if (clr) begin
      shadowQ <= '0;
      shiftQ  <= '0;
    end else begin
      if (shLoad) shadowQ <= shData;
      // The last preload byte lands on the same edge as the first transfer, so bypass it.
      if (xfer)         shiftQ <= shLoad ? shData : shadowQ;
      else if (shiftEn) shiftQ <= {shiftQ[6:0], 1'b0};
    end
  end

  assign neo = active & en & bitPattern(shiftQ[7], tick);

endmodule

// File: rtl/anton_neopixel_multi_stream.sv
// Multi-channel WS2812 streamer: one shared byte buffer, round-robin prefetch, per-lane encoders.
module anton_neopixel_multi_stream
  import anton_neopixel_multi_stream_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int PIXELS_PER_CH = 64,
  parameter int RESET_DELAY   = RESET_DELAY_DEFAULT,
  localparam int PW = (PIXELS_PER_CH > 1) ? $clog2(PIXELS_PER_CH) : 1,
  localparam int AW = $clog2(CHANNELS * PIXELS_PER_CH * 4)
) (
  input  logic                clk6_4mhz,
  input  logic                resetn,
  input  logic                start,
  input  logic                stop,
  input  logic                regCtrl32bit,
  input  logic                regCtrlLoop,
  input  logic [CHANNELS-1:0] chEnable,
  input  logic [PW-1:0]       pixelsMax,
  output logic [AW-1:0]       rdAddr,
  output logic                rdEn,
  input  logic [7:0]          rdData,
  output logic [CHANNELS-1:0] neoData,
  output logic [1:0]          state,
  output logic                frameDone
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SW = $clog2(RESET_DELAY + 1);
  localparam logic [4:0]    CH5       = 5'(CHANNELS);
  localparam logic [5:0]    CH6       = 6'(CHANNELS);
  localparam logic [SW-1:0] SYNC_LAST = SW'(RESET_DELAY - 1);
  localparam logic [PW-1:0] PIX_LAST  = PW'(PIXELS_PER_CH - 1);

  npState_t          stateQ, stateD;
  logic [4:0]        preCnt;
  logic [2:0]        tickQ, bitCnt;
  logic [5:0]        byteCycle;
  logic [PW-1:0]     pixQ, pixMaxQ, nextPix, pixSel, pixMaxClamp;
  logic [1:0]        bipQ, nextBip, bipSel, lastBip;
  logic [SW-1:0]     syncCnt;
  logic              bpp32Q;
  logic [CHANNELS-1:0] chEnQ;
  logic              rdVldQ;
  logic [CW-1:0]     rdCh, rdChQ;
  logic [AW-1:0]     rdAddrC;
  logic              lastByte, byteEnd, preDone, syncDone, accStart, sample;
  logic              xfer, shiftEn, streaming;

  assign state       = stateQ;
  assign byteCycle   = {bitCnt, tickQ};
  assign streaming   = (stateQ == NP_STREAM);
  assign lastBip     = bpp32Q ? 2'd3 : 2'd2;
  assign lastByte    = (pixQ == pixMaxQ) && (bipQ == lastBip);
  assign byteEnd     = streaming && (byteCycle == 6'd63);
  assign preDone     = (stateQ == NP_PRELOAD) && (preCnt == CH5);
  assign syncDone    = (stateQ == NP_SYNC) && (syncCnt == SYNC_LAST);
  assign accStart    = (stateQ == NP_IDLE) && start && !stop;
  assign sample      = accStart || (syncDone && regCtrlLoop && !stop);
  assign frameDone   = syncDone && !stop;
  assign xfer        = preDone || (byteEnd && !lastByte);
  assign shiftEn     = streaming && (tickQ == 3'd7);
  assign pixMaxClamp = (int'(pixelsMax) > PIXELS_PER_CH - 1) ? PIX_LAST : pixelsMax;

  always_comb begin
    nextBip = bipQ + 2'd1;
    nextPix = pixQ;
    if (bipQ == lastBip) begin
      nextBip = 2'd0;
      nextPix = pixQ + 1'b1;
    end
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      NP_IDLE:    if (start)                stateD = NP_PRELOAD;
      NP_PRELOAD: if (preDone)              stateD = NP_STREAM;
      NP_STREAM:  if (byteEnd && lastByte)  stateD = NP_SYNC;
      NP_SYNC:    if (syncDone)             stateD = regCtrlLoop ? NP_PRELOAD : NP_IDLE;
      default:                              stateD = NP_IDLE;
    endcase
    if (stop) stateD = NP_IDLE;
  end

  // Fixed read schedule: preload byte 0 for every lane, then prefetch the next byte
  // during the first CHANNELS cycles of each byte; nothing past the frame's last byte.
  always_comb begin
    rdEn   = 1'b0;
    rdCh   = '0;
    pixSel = pixQ;
    bipSel = bipQ;
    if ((stateQ == NP_PRELOAD) && (preCnt < CH5)) begin
      rdEn = 1'b1;
      rdCh = preCnt[CW-1:0];
    end else if (streaming && (byteCycle < CH6) && !lastByte) begin
      rdEn   = 1'b1;
      rdCh   = byteCycle[CW-1:0];
      pixSel = nextPix;
      bipSel = nextBip;
    end
  end

  assign rdAddrC = AW'(rdCh) * AW'(PIXELS_PER_CH * 4)
                 + AW'(pixSel) * AW'(bpp32Q ? 3'd4 : 3'd3)
                 + AW'(bipSel);
  assign rdAddr  = rdEn ? rdAddrC : '0;

  always_ff @(posedge clk6_4mhz or negedge resetn) begin
    if (!resetn) begin
      stateQ  <= NP_IDLE;
      preCnt  <= '0;
      tickQ   <= '0;
      bitCnt  <= '0;
      pixQ    <= '0;
      bipQ    <= '0;
      syncCnt <= '0;
      rdVldQ  <= 1'b0;
      rdChQ   <= '0;
    end else begin
      stateQ <= stateD;
      rdVldQ <= rdEn && !stop;
      rdChQ  <= rdCh;
      if (stop) begin
        preCnt  <= '0;
        tickQ   <= '0;
        bitCnt  <= '0;
        pixQ    <= '0;
        bipQ    <= '0;
        syncCnt <= '0;
      end else begin
        case (stateQ)
          NP_IDLE: if (start) begin
            preCnt <= '0;
            pixQ   <= '0;
            bipQ   <= '0;
          end
          NP_PRELOAD: preCnt <= preDone ? '0 : preCnt + 1'b1;
          NP_STREAM: begin
            tickQ <= tickQ + 1'b1;
            if (tickQ == 3'd7) bitCnt <= bitCnt + 1'b1;
            if (byteEnd) begin
              pixQ <= lastByte ? '0 : nextPix;
              bipQ <= lastByte ? '0 : nextBip;
            end
          end
          NP_SYNC: syncCnt <= syncDone ? '0 : syncCnt + 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Frame configuration is only latched at frame boundaries.
  always_ff @(posedge clk6_4mhz or negedge resetn) begin
    if (!resetn) begin
      bpp32Q  <= 1'b0;
      chEnQ   <= '0;
      pixMaxQ <= '0;
    end else if (sample) begin
      bpp32Q  <= regCtrl32bit;
      chEnQ   <= chEnable;
      pixMaxQ <= pixMaxClamp;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : gLane
    anton_neopixel_bit_encoder uEnc (
      .clk6_4mhz (clk6_4mhz),
      .resetn    (resetn),
      .clr       (stop),
      .shLoad    (rdVldQ && (rdChQ == CW'(g))),
      .shData    (rdData),
      .xfer      (xfer),
      .shiftEn   (shiftEn),
      .en        (chEnQ[g]),
      .active    (streaming),
      .tick      (tickQ),
      .neo       (neoData[g])
    );
  end

endmodule
